// File: rtl/cpu_io_pkg.sv
// Shared CPU I/O constants: memory-mapped IO word addresses
// and the default switch debounce interval.
package cpu_io_pkg;

   localparam int HEX0     = 0;
   localparam int HEX1     = 1;
   localparam int HEX2     = 2;
   localparam int HEX3     = 3;
   localparam int HEX4     = 4;
   localparam int HEX5     = 5;
   localparam int LEDS     = 6;
   localparam int SWITCHES = 7;

   // 10 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter,
// registered clean level and a one-cycle change pulse.
// Ports: clk, rst (async low), sw_raw in; sw_clean, sw_changed out.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   output logic sw_clean,
   output logic sw_changed
);

   localparam logic [CNT_W-1:0] LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         cnt        <= '0;
         sw_clean   <= 1'b0;
         sw_changed <= 1'b0;
      end else begin
         sync1      <= sw_raw;
         sync2      <= sync1;
         sw_changed <= 1'b0;
         if (sync2 == sw_clean) begin
            // any bounce back restarts the stability window
            cnt <= '0;
         end else if (cnt == LAST) begin
            sw_clean   <= sync2;
            cnt        <= '0;
            sw_changed <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH board switches into the clean switch word.
// Ports: clk, rst (async low), sw_raw in; sw_clean,
// sw_changed (per-bit pulse), any_change (OR of pulses) out.
module switch_debounce
   import cpu_io_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_changed,
   output logic             any_change
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk        (clk),
         .rst        (rst),
         .sw_raw     (sw_raw[i]),
         .sw_clean   (sw_clean[i]),
         .sw_changed (sw_changed[i])
      );
   end

   assign any_change = |sw_changed;

endmodule
